vector_mac_sequencer: RTL and testbench
=======================================

VECTOR_MAC_SEQUENCER -- requirements
Module: vector_mac_sequencer

Interface
REQ-001 SHALL have parameter MAX_GROUPS, default 8, meaning the maximum register groups per instruction (LMUL).
REQ-002 SHALL have parameter WAIT_TIMEOUT, default 64, meaning the maximum cycles in WAIT before an error is flagged.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 issue_valid  in  1  instruction request.
REQ-006 issue_ready  out  1  sequencer can accept.
REQ-007 issue_op  in  3  accum_op encoding: 000 VMACC_VV .. 111 VNMSUB_VX.
REQ-008 issue_sew  in  2  00=8b, 01=16b, 10=32b, 11=illegal.
REQ-009 issue_signed  in  1  signed multiply.
REQ-010 issue_lmul  in  3  register groups minus one (0..MAX_GROUPS-1).
REQ-011 issue_vd, issue_vs1, issue_vs2  in  5 each  base register indices.
REQ-012 rd_addr_a, rd_addr_b, rd_addr_c  out  5 each  register-file read addresses for data_A (vs1), data_B (vs2) and data_C (vd).
REQ-013 mau_accum_op  out  3,  mau_sew  out  2,  mau_signed  out  1  latched configuration to the multiply-add unit.
REQ-014 mau_ctrl  out  1,  mau_sew_16_32  out  1,  mau_sew_32  out  1  decoded adder controls.
REQ-015 mau_count_0  out  1  multiplier start/restart strobe.
REQ-016 mau_sum_done  in  1  product_sum_done from the multiply-add unit.
REQ-017 wb_valid  out  1,  wb_addr  out  5,  wb_ready  in  1  writeback handshake.
REQ-018 busy  out  1,  done  out  1,  error  out  1  status outputs.

Function
REQ-019 The FSM SHALL have the states IDLE, LAUNCH, WAIT, WB and DONE.
REQ-020 issue_ready SHALL equal (state==IDLE) && !reset, and busy SHALL equal !(state==IDLE).
REQ-021 An accept (issue_valid && issue_ready) SHALL latch op, sew, signed, lmul and the base indices, clear the group counter g to 0, and move the FSM to LAUNCH on the next cycle.
REQ-022 An accept with issue_sew==11 or issue_lmul>=MAX_GROUPS SHALL NOT be latched; the FSM stays in IDLE and error pulses high for one cycle.
REQ-023 In LAUNCH, mau_count_0 SHALL be high for exactly one cycle, followed by an unconditional move to WAIT.
REQ-024 mau_count_0 SHALL be low in all other states.
REQ-025 In WAIT, the sequencer SHALL hold until mau_sum_done==1, then move to WB.
REQ-026 A mau_sum_done pulse outside WAIT SHALL be ignored.
REQ-027 A WAIT cycle counter SHALL reset on entry to WAIT.
REQ-028 If the WAIT counter reaches WAIT_TIMEOUT without mau_sum_done, error SHALL pulse for one cycle and the FSM SHALL return to IDLE with no writeback.
REQ-029 In WB, wb_valid SHALL be held high, with wb_addr stable, until wb_ready.
REQ-030 On a WB handshake with g<lmul, g SHALL increment and the FSM SHALL return to LAUNCH.
REQ-031 On a WB handshake with g==lmul, the FSM SHALL move to DONE.
REQ-032 In DONE, done SHALL be high for exactly one cycle, followed by a move to IDLE.
REQ-033 An accept SHALL be possible in the cycle after DONE.
REQ-034 rd_addr_a SHALL equal vs1+g, rd_addr_b SHALL equal vs2+g, rd_addr_c SHALL equal vd+g, and wb_addr SHALL equal vd+g, all modulo 32 (5-bit wrap, e.g. 31+1=0).
REQ-035 The read addresses SHALL be stable from LAUNCH through the end of WB.
REQ-036 mau_ctrl SHALL equal op[1] (subtract for VNMSAC/VNMSUB).
REQ-037 mau_sew_16_32 SHALL equal (sew!=00), and mau_sew_32 SHALL equal (sew==10).
REQ-038 All mau_* configuration outputs SHALL be registered and constant for the whole instruction.
REQ-039 The minimum latency per group SHALL be LAUNCH 1 + WAIT k + WB 1 cycles, where k≥1 is the unit's latency; total latency SHALL be that figure times (lmul+1), plus 1 cycle for DONE.
REQ-040 issue_valid while busy SHALL have no effect.

Reset
REQ-041 While reset is high, the FSM SHALL go to IDLE on the clock edge and g and the WAIT counter SHALL clear to 0.
REQ-042 During reset, all latched fields SHALL clear to 0, and wb_valid, mau_count_0, done, error and busy SHALL be 0.
REQ-043 During reset, issue_ready SHALL be 0.
REQ-044 Reset asserted mid-instruction (any state) SHALL abort the instruction without a done or error pulse and without a further wb_valid.

Verification
REQ-045 Bench: VMACC_VV, sew=01, lmul=0, vd=4, vs1=8, vs2=12; sum_done 3 cycles after LAUNCH; wb_ready=1 -> one count_0 pulse, rd_addr_a/b/c=8/12/4, wb_addr=4, ctrl=0, sew_16_32=1, sew_32=0, done 1 cycle after WB.
REQ-046 Bench: VNMSUB_VX, sew=10, lmul=3, vd=30, vs1=0, vs2=16 -> 4 count_0 pulses, wb_addr sequence 30,31,0,1, ctrl=1, sew_32=1, a single done.
REQ-047 Bench: wb_ready held low 5 cycles in WB -> wb_valid and wb_addr held stable for 5 cycles, no extra count_0 pulse, progress on the first wb_ready=1.
REQ-048 Bench: issue with sew=11, then lmul=7 with MAX_GROUPS=4 -> one error pulse each, busy stays 0.
REQ-049 Bench: no sum_done for WAIT_TIMEOUT cycles -> one error pulse, return to IDLE, wb_valid never asserted.
REQ-050 Bench: reset asserted in WAIT of group 2 -> next cycle IDLE with all outputs 0, no done; after deassertion, a new issue is accepted normally.

Source files
------------

// File: rtl/vector_mac_sequencer.sv
// vector_mac_sequencer: steps one vector multiply-accumulate instruction through
// its LMUL register groups, launching the multiply-add unit and writing back each group.
module vector_mac_sequencer #(
  parameter int MAX_GROUPS = 8,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid,
  output logic       issue_ready,
  input  logic [2:0] issue_op,
  input  logic [1:0] issue_sew,
  input  logic       issue_signed,
  input  logic [2:0] issue_lmul,
  input  logic [4:0] issue_vd,
  input  logic [4:0] issue_vs1,
  input  logic [4:0] issue_vs2,
  output logic [4:0] rd_addr_a,
  output logic [4:0] rd_addr_b,
  output logic [4:0] rd_addr_c,
  output logic [2:0] mau_accum_op,
  output logic [1:0] mau_sew,
  output logic       mau_signed,
  output logic       mau_ctrl,
  output logic       mau_sew_16_32,
  output logic       mau_sew_32,
  output logic       mau_count_0,
  input  logic       mau_sum_done,
  output logic       wb_valid,
  output logic [4:0] wb_addr,
  input  logic       wb_ready,
  output logic       busy,
  output logic       done,
  output logic       error
);
  localparam int TW = $clog2(WAIT_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, WB, DONE} state_t;
  state_t state;
  logic [2:0] g, lmul;
  logic [4:0] vd, vs1, vs2;
  logic [TW-1:0] wcnt;
  logic accept, bad;
  assign issue_ready = state == IDLE && !reset;
  assign busy = state != IDLE;
  assign accept = issue_valid && issue_ready;
  assign bad = issue_sew == 2'b11 || int'(issue_lmul) >= MAX_GROUPS;
  // Group addresses wrap within the 32-entry register file.
  assign rd_addr_a = vs1 + 5'(g);
  assign rd_addr_b = vs2 + 5'(g);
  assign rd_addr_c = vd + 5'(g);
  assign wb_addr = vd + 5'(g);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      g <= '0;
      lmul <= '0;
      vd <= '0;
      vs1 <= '0;
      vs2 <= '0;
      wcnt <= '0;
      mau_accum_op <= '0;
      mau_sew <= '0;
      mau_signed <= 1'b0;
      mau_ctrl <= 1'b0;
      mau_sew_16_32 <= 1'b0;
      mau_sew_32 <= 1'b0;
      mau_count_0 <= 1'b0;
      wb_valid <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      mau_count_0 <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && bad) error <= 1'b1;
          else if (accept) begin
            lmul <= issue_lmul;
            vd <= issue_vd;
            vs1 <= issue_vs1;
            vs2 <= issue_vs2;
            g <= '0;
            mau_accum_op <= issue_op;
            mau_sew <= issue_sew;
            mau_signed <= issue_signed;
            mau_ctrl <= issue_op[1];
            mau_sew_16_32 <= issue_sew != 2'b00;
            mau_sew_32 <= issue_sew == 2'b10;
            mau_count_0 <= 1'b1;
            state <= LAUNCH;
          end
        end
        LAUNCH: begin
          wcnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (mau_sum_done) begin
            wb_valid <= 1'b1;
            state <= WB;
          end else if (wcnt == TW'(WAIT_TIMEOUT - 1)) begin
            error <= 1'b1;
            state <= IDLE;
          end else wcnt <= wcnt + 1'b1;
        end
        WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            if (g == lmul) begin
              done <= 1'b1;
              state <= DONE;
            end else begin
              g <= g + 1'b1;
              mau_count_0 <= 1'b1;
              state <= LAUNCH;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_mac_sequencer.sv
// tb_vector_mac_sequencer: directed stimulus with a writeback-address scoreboard.
module tb_vector_mac_sequencer;
  logic clk = 1'b0;
  logic reset, issue_valid, issue_ready, issue_signed;
  logic [2:0] issue_op, issue_lmul;
  logic [1:0] issue_sew;
  logic [4:0] issue_vd, issue_vs1, issue_vs2;
  logic [4:0] rd_addr_a, rd_addr_b, rd_addr_c, wb_addr;
  logic [2:0] mau_accum_op;
  logic [1:0] mau_sew;
  logic mau_signed, mau_ctrl, mau_sew_16_32, mau_sew_32, mau_count_0, mau_sum_done;
  logic wb_valid, wb_ready, busy, done, error;
  int compared = 0, mismatched = 0;
  int c0_cnt, done_cnt, err_cnt, wbv_cnt, n;
  bit sd_en = 1'b1;
  int sd_lat = 3;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  vector_mac_sequencer #(.MAX_GROUPS(4), .WAIT_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_sew(issue_sew), .issue_signed(issue_signed),
    .issue_lmul(issue_lmul), .issue_vd(issue_vd), .issue_vs1(issue_vs1), .issue_vs2(issue_vs2),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
    .mau_accum_op(mau_accum_op), .mau_sew(mau_sew), .mau_signed(mau_signed),
    .mau_ctrl(mau_ctrl), .mau_sew_16_32(mau_sew_16_32), .mau_sew_32(mau_sew_32),
    .mau_count_0(mau_count_0), .mau_sum_done(mau_sum_done),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_ready(wb_ready),
    .busy(busy), .done(done), .error(error)
  );

  // Multiply-add unit model: answers each launch after sd_lat cycles unless reset intervenes.
  initial begin
    mau_sum_done = 1'b0;
    forever begin
      @(negedge clk);
      if (mau_count_0 && sd_en) begin
        repeat (sd_lat - 1) begin
          @(negedge clk);
          if (reset) break;
        end
        if (!reset) begin
          mau_sum_done = 1'b1;
          @(negedge clk);
          mau_sum_done = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Observe the current cycle mid-period, then advance past the next rising edge.
  task automatic tick();
    logic [4:0] e;
    @(negedge clk);
    c0_cnt += int'(mau_count_0);
    done_cnt += int'(done);
    err_cnt += int'(error);
    wbv_cnt += int'(wb_valid);
    if (!reset && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) check("wb_unexpected", 32'(wb_addr), 32'd99);
      else begin
        e = exp_q.pop_front();
        check("wb_addr", 32'(wb_addr), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    c0_cnt = 0;
    done_cnt = 0;
    err_cnt = 0;
    wbv_cnt = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] sew, input logic sgn,
                       input logic [2:0] lmul, input logic [4:0] vd, input logic [4:0] vs1,
                       input logic [4:0] vs2, input int nwb);
    for (int i = 0; i < nwb; i++) exp_q.push_back(5'(vd + 5'(i)));
    issue_op = op;
    issue_sew = sew;
    issue_signed = sgn;
    issue_lmul = lmul;
    issue_vd = vd;
    issue_vs1 = vs1;
    issue_vs2 = vs2;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    reset = 1'b1;
    issue_valid = 1'b0;
    issue_op = '0;
    issue_sew = '0;
    issue_signed = 1'b0;
    issue_lmul = '0;
    issue_vd = '0;
    issue_vs1 = '0;
    issue_vs2 = '0;
    wb_ready = 1'b1;
    clear_counts();
    repeat (3) tick();
    check("rst_ready", 32'(issue_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_outs", 32'({wb_valid, mau_count_0, done, error}), 0);
    reset = 1'b0;
    tick();
    check("idle_ready", 32'(issue_ready), 1);

    clear_counts();
    issue(3'd0, 2'b01, 1'b0, 3'd0, 5'd4, 5'd8, 5'd12, 1);
    check("t1_busy", 32'(busy), 1);
    check("t1_count0", 32'(mau_count_0), 1);
    check("t1_rd_a", 32'(rd_addr_a), 8);
    check("t1_rd_b", 32'(rd_addr_b), 12);
    check("t1_rd_c", 32'(rd_addr_c), 4);
    check("t1_cfg", 32'({mau_accum_op, mau_sew, mau_ctrl, mau_sew_16_32, mau_sew_32}), 32'b000_01_0_1_0);
    wait_done(n);
    check("t1_latency", n, 4);
    tick();
    check("t1_count0_pulses", c0_cnt, 1);
    check("t1_done_pulses", done_cnt, 1);
    check("t1_ready_after", 32'(issue_ready), 1);

    clear_counts();
    issue(3'd7, 2'b10, 1'b1, 3'd3, 5'd30, 5'd0, 5'd16, 4);
    check("t2_cfg", 32'({mau_accum_op, mau_sew, mau_signed, mau_ctrl, mau_sew_16_32, mau_sew_32}), 32'b111_10_1_1_1_1);
    wait_done(n);
    check("t2_latency", n, 16);
    check("t2_cfg_end", 32'({mau_ctrl, mau_sew_32}), 32'b11);
    tick();
    check("t2_count0_pulses", c0_cnt, 4);
    check("t2_done_pulses", done_cnt, 1);

    clear_counts();
    wb_ready = 1'b0;
    issue(3'd1, 2'b00, 1'b0, 3'd0, 5'd5, 5'd6, 5'd7, 1);
    n = 0;
    while (!wb_valid && n < 50) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("t3_wb_valid", 32'(wb_valid), 1);
      check("t3_wb_addr", 32'(wb_addr), 5);
      if (i == 4) wb_ready = 1'b1;
      tick();
    end
    check("t3_done", 32'(done), 1);
    tick();
    check("t3_count0_pulses", c0_cnt, 1);

    clear_counts();
    issue(3'd0, 2'b11, 1'b0, 3'd0, 5'd1, 5'd2, 5'd3, 0);
    check("t4_sew_err", 32'(error), 1);
    check("t4_sew_busy", 32'(busy), 0);
    tick();
    check("t4_err_clear", 32'(error), 0);
    issue(3'd0, 2'b00, 1'b0, 3'd7, 5'd1, 5'd2, 5'd3, 0);
    check("t4_lmul_err", 32'(error), 1);
    check("t4_lmul_busy", 32'(busy), 0);
    tick();
    check("t4_err_pulses", err_cnt, 2);

    clear_counts();
    sd_en = 1'b0;
    issue(3'd2, 2'b00, 1'b0, 3'd0, 5'd9, 5'd9, 5'd9, 0);
    n = 0;
    while (!error && n < 100) begin
      tick();
      n++;
    end
    check("t5_timeout_latency", n, 17);
    check("t5_idle", 32'(busy), 0);
    tick();
    check("t5_err_pulses", err_cnt, 1);
    check("t5_no_wb", wbv_cnt, 0);
    sd_en = 1'b1;

    clear_counts();
    sd_lat = 6;
    issue(3'd0, 2'b00, 1'b0, 3'd3, 5'd10, 5'd20, 5'd3, 2);
    n = 0;
    while (c0_cnt < 3 && n < 100) begin
      tick();
      n++;
    end
    check("t6_g2_rd_a", 32'(rd_addr_a), 22);
    reset = 1'b1;
    tick();
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_ready", 32'(issue_ready), 0);
    check("t6_rst_outs", 32'({wb_valid, mau_count_0, done, error, mau_sew_16_32, mau_ctrl}), 0);
    check("t6_rst_addr", 32'({rd_addr_a, wb_addr}), 0);
    reset = 1'b0;
    repeat (8) tick();
    check("t6_no_done", done_cnt, 0);
    check("t6_no_err", err_cnt, 0);
    sd_lat = 3;
    clear_counts();
    issue(3'd2, 2'b00, 1'b0, 3'd1, 5'd2, 5'd3, 5'd4, 2);
    wait_done(n);
    check("t6_reissue_latency", n, 8);
    tick();
    check("t6_reissue_count0", c0_cnt, 2);
    check("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
